// File: rtl/sum_diff_pkg.sv
// Shared definitions for the sum/difference pipeline: mode encodings,
// default widths and the packed {diff, sum} helper used by sum_diff_calc.
package sum_diff_pkg;

  localparam logic MODE_PAIR = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  // Widest operand the helper function supports.
  localparam int MAX_W = 32;

  // Zero-extends a and b to 2*width bits and returns {a-b, a+b}, each half
  // 2*width bits wide, in the low 4*width bits of the result.
  function automatic logic [4*MAX_W-1:0] sum_diff_pack(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int               width
  );
    logic [2*MAX_W-1:0] mask;
    logic [2*MAX_W-1:0] s;
    logic [2*MAX_W-1:0] d;
    mask = {(2*MAX_W){1'b1}} >> (2*MAX_W - 2*width);
    s    = ({{MAX_W{1'b0}}, a} + {{MAX_W{1'b0}}, b}) & mask;
    d    = ({{MAX_W{1'b0}}, a} - {{MAX_W{1'b0}}, b}) & mask;
    return ({{(2*MAX_W){1'b0}}, d} << (2*width)) | {{(2*MAX_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/sum_diff_calc.sv
// Combinational sum/difference of one operand pair. Input is {a, b}, output
// is {a-b, a+b} with both halves zero-extended to 2*WIDTH bits.
module sum_diff_calc
  import sum_diff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] ab,
  output logic [4*WIDTH-1:0] y
);

  logic [4*MAX_W-1:0] pack_w;

  // Evaluate the shared helper at this instance's width.
  always_comb begin
    pack_w = sum_diff_pack(MAX_W'(ab[2*WIDTH-1:WIDTH]), MAX_W'(ab[WIDTH-1:0]), WIDTH);
  end

  assign y = pack_w[4*WIDTH-1:0];

  // Bits above 4*WIDTH are always zero; fold them away explicitly.
  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^pack_w[4*MAX_W-1:4*WIDTH];
  end

endmodule

// File: rtl/sum_diff_pipe.sv
// Two-stage sum/difference pipeline with valid/ready handshakes.
// S1 holds the accepted beat; S2 drives out_valid/out_y/out_cnt.
// PAIR beats produce one result each; ACC beats accumulate until in_last.
// Optional feature macro: SUM_DIFF_FLAGS_EN adds out_flags[1:0]
// ([0] sticky sum carry across the result's beats, [1] MSB of diff).
module sum_diff_pipe
  import sum_diff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WIDTH-1:0] out_y,
  output logic [CNT_W-1:0]   out_cnt
`ifdef SUM_DIFF_FLAGS_EN
  ,
  output logic [1:0]         out_flags
`endif
);

  localparam int HW = 2 * WIDTH;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic               s1_mode;
  logic               s1_last;

  logic [4*WIDTH-1:0] beat_y;
  logic [HW-1:0]      beat_sum;
  logic [HW-1:0]      beat_diff;

  logic [HW-1:0]      acc_sum;
  logic [HW-1:0]      acc_diff;
  logic [CNT_W-1:0]   acc_cnt;
  logic [HW-1:0]      sum_next;
  logic [HW-1:0]      diff_next;

  logic               s1_acc_body;
  logic               s1_adv;
  logic               in_fire;
  logic               s2_load;

  sum_diff_calc #(.WIDTH(WIDTH)) u_calc (
    .ab ({s1_a, s1_b}),
    .y  (beat_y)
  );

  assign beat_sum  = beat_y[HW-1:0];
  assign beat_diff = beat_y[4*WIDTH-1:HW];
  assign diff_next = acc_diff + beat_diff;

`ifdef SUM_DIFF_FLAGS_EN
  logic sum_carry;
  logic acc_carry;
  assign {sum_carry, sum_next} = {1'b0, acc_sum} + {1'b0, beat_sum};
`else
  assign sum_next = acc_sum + beat_sum;
`endif

  // A non-last ACC beat never needs S2, so it can drain even while S2 stalls.
  assign s1_acc_body = (s1_mode == MODE_ACC) && !s1_last;
  assign s1_adv      = s1_valid && (!out_valid || out_ready || s1_acc_body);
  assign in_ready    = !s1_valid || s1_adv;
  assign in_fire     = in_valid && in_ready;
  assign s2_load     = s1_adv && !s1_acc_body;

  // ---- S1: input register, occupancy flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S1 beat payload, captured on every accepted beat.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_a    <= in_a;
      s1_b    <= in_b;
      s1_mode <= in_mode;
      s1_last <= in_last;
    end
  end

  // Packet accumulators: add body beats, clear when the last beat leaves S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sum  <= '0;
      acc_diff <= '0;
      acc_cnt  <= '0;
    end else if (s1_adv && (s1_mode == MODE_ACC)) begin
      if (!s1_last) begin
        acc_sum  <= sum_next;
        acc_diff <= diff_next;
        acc_cnt  <= sat_inc(acc_cnt);
      end else begin
        acc_sum  <= '0;
        acc_diff <= '0;
        acc_cnt  <= '0;
      end
    end
  end

  // ---- S2: output register, holds while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cnt   <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      if (s1_mode == MODE_PAIR) begin
        out_y   <= beat_y;
        out_cnt <= CNT_W'(1);
      end else begin
        out_y   <= {diff_next, sum_next};
        out_cnt <= sat_inc(acc_cnt);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SUM_DIFF_FLAGS_EN
  // Sticky carry of the packet sum, cleared together with the accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_carry <= 1'b0;
    end else if (s1_adv && (s1_mode == MODE_ACC)) begin
      acc_carry <= s1_last ? 1'b0 : (acc_carry | sum_carry);
    end
  end

  // Flags registered alongside out_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags <= 2'b00;
    end else if (s2_load) begin
      if (s1_mode == MODE_PAIR) begin
        out_flags <= {beat_diff[HW-1], 1'b0};
      end else begin
        out_flags <= {diff_next[HW-1], acc_carry | sum_carry};
      end
    end
  end
`endif

endmodule

// File: tb/tb_sum_diff_pipe.sv
// Self-checking bench for sum_diff_pipe (WIDTH=8, CNT_W=8): vector table,
// hand sequences for latency/backpressure/reset/saturation, and randomized
// traffic checked by a packet-level scoreboard.
module tb_sum_diff_pipe;
  import sum_diff_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [4*W-1:0] out_y;
  logic [CW-1:0] out_cnt;
`ifdef SUM_DIFF_FLAGS_EN
  logic [1:0]    out_flags;
`endif

  always #5 clk = ~clk;

  sum_diff_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_cnt   (out_cnt)
`ifdef SUM_DIFF_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] y;
    logic [7:0]  cnt;
    logic [1:0]  flags;
  } res_t;

  typedef struct {
    int a;
    int b;
  } beat_t;

  res_t  exp_q[$];
  beat_t pkt[$];
  res_t  sb_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pair_y(input int a, input int b);
    logic [15:0] s;
    logic [15:0] d;
    s = 16'(a + b);
    d = 16'(a - b);
    return {d, s};
  endfunction

  // Reference model: one result per PAIR beat, one per ACC packet.
  function automatic void model_beat(input int a, input int b, input logic mode, input logic last);
    res_t  r;
    beat_t bt;
    longint ts;
    longint td;
    int n;
    if (mode == MODE_PAIR) begin
      r.y     = pair_y(a, b);
      r.cnt   = 8'd1;
      r.flags = {r.y[31], 1'b0};
      exp_q.push_back(r);
    end else begin
      bt.a = a;
      bt.b = b;
      pkt.push_back(bt);
      if (last) begin
        ts = 0;
        td = 0;
        foreach (pkt[i]) begin
          ts += pkt[i].a + pkt[i].b;
          td += pkt[i].a - pkt[i].b;
        end
        n       = pkt.size();
        r.y     = {16'(td), 16'(ts)};
        r.cnt   = (n > 255) ? 8'd255 : 8'(n);
        r.flags = {r.y[31], (ts >= 65536) ? 1'b1 : 1'b0};
        exp_q.push_back(r);
        pkt.delete();
      end
    end
  endfunction

  // Scoreboard: observe transfers mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pkt.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got y=%h expected no result", out_y);
        end else begin
          sb_r = exp_q.pop_front();
          check("sb_y", 64'(out_y), 64'(sb_r.y));
          check("sb_cnt", 64'(out_cnt), 64'(sb_r.cnt));
`ifdef SUM_DIFF_FLAGS_EN
          check("sb_flags", 64'(out_flags), 64'(sb_r.flags));
`endif
        end
      end
      if (in_valid && in_ready) model_beat(int'(in_a), int'(in_b), in_mode, in_last);
    end
  end

  // Offer one beat and hold it until accepted; leaves in_valid high.
  task automatic send(input int a, input int b, input logic mode, input logic last);
    bit ok;
    ok       = 0;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_mode  = mode;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      in_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance of a=%0d b=%0d", a, b);
    end
  endtask

  task automatic wait_out(input string name, output bit got);
    got = 0;
    for (int t = 0; t < 20; t++) begin
      if (out_valid) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1", name);
    end
  endtask

  typedef struct {
    int          a;
    int          b;
    logic        mode;
    logic        last;
    logic        expv;
    logic [31:0] y;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt[12];
  bit   rnd_on;

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  // Random consumer backpressure while rnd_on is set.
  initial begin
    wait (rnd_on);
    while (rnd_on) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  end

  initial begin
    bit got;
    logic [31:0] held;

    vt[0]  = '{15,  12,  MODE_PAIR, 1'b0, 1'b1, 32'h0003_001B, 8'd1};
    vt[1]  = '{12,  15,  MODE_PAIR, 1'b0, 1'b1, 32'hFFFD_001B, 8'd1};
    vt[2]  = '{0,   0,   MODE_PAIR, 1'b1, 1'b1, 32'h0000_0000, 8'd1};
    vt[3]  = '{255, 255, MODE_PAIR, 1'b0, 1'b1, 32'h0000_01FE, 8'd1};
    vt[4]  = '{0,   255, MODE_PAIR, 1'b0, 1'b1, 32'hFF01_00FF, 8'd1};
    vt[5]  = '{10,  3,   MODE_ACC,  1'b0, 1'b0, 32'h0,         8'd0};
    vt[6]  = '{20,  5,   MODE_ACC,  1'b0, 1'b0, 32'h0,         8'd0};
    vt[7]  = '{1,   1,   MODE_ACC,  1'b1, 1'b1, 32'h0016_0028, 8'd3};
    vt[8]  = '{7,   2,   MODE_ACC,  1'b0, 1'b0, 32'h0,         8'd0};
    vt[9]  = '{3,   5,   MODE_PAIR, 1'b0, 1'b1, 32'hFFFE_0008, 8'd1};
    vt[10] = '{1,   0,   MODE_ACC,  1'b1, 1'b1, 32'h0006_000A, 8'd2};
    vt[11] = '{255, 0,   MODE_PAIR, 1'b0, 1'b1, 32'h00FF_00FF, 8'd1};

    rnd_on    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = MODE_PAIR;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_cnt", 64'(out_cnt), 64'd0);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: accepted on edge E0, visible after E1.
    send(15, 12, MODE_PAIR, 1'b0);
    in_valid = 1'b0;
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_y", 64'(out_y), 64'h0003_001B);
    @(posedge clk);
    #1;

    // Vector table, one beat at a time.
    for (int i = 0; i < 12; i++) begin
      send(vt[i].a, vt[i].b, vt[i].mode, vt[i].last);
      in_valid = 1'b0;
      if (vt[i].expv) begin
        wait_out("vec", got);
        if (got) begin
          check($sformatf("vec%0d_y", i), 64'(out_y), 64'(vt[i].y));
          check($sformatf("vec%0d_cnt", i), 64'(out_cnt), 64'(vt[i].cnt));
`ifdef SUM_DIFF_FLAGS_EN
          check($sformatf("vec%0d_flags", i), 64'(out_flags), 64'({vt[i].y[31], 1'b0}));
`endif
        end
        @(posedge clk);
        #1;
      end else begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("vec%0d_no_out", i), 64'(out_valid), 64'd0);
          @(posedge clk);
          #1;
        end
      end
    end

    // Backpressure: S2 holds, S1 fills, in_ready drops.
    out_ready = 1'b0;
    send(100, 1, MODE_PAIR, 1'b0);
    send(2, 200, MODE_PAIR, 1'b0);
    held     = pair_y(100, 1);
    in_a     = 8'd50;
    in_b     = 8'd50;
    in_mode  = MODE_PAIR;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_y", 64'(out_y), 64'(held));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(50, 50, MODE_PAIR, 1'b0);
    send(255, 254, MODE_PAIR, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a packet discards the partial sum.
    send(9, 9, MODE_ACC, 1'b0);
    send(3, 1, MODE_ACC, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    send(4, 2, MODE_ACC, 1'b1);
    in_valid = 1'b0;
    wait_out("mid_rst", got);
    if (got) begin
      check("mid_rst_y", 64'(out_y), 64'h0002_0006);
      check("mid_rst_cnt", 64'(out_cnt), 64'd1);
    end
    @(posedge clk);
    #1;

    // Beat counter saturates at 255.
    for (int i = 0; i < 260; i++) send(1, 0, MODE_ACC, (i == 259));
    in_valid = 1'b0;
    wait_out("sat", got);
    if (got) begin
      check("sat_cnt", 64'(out_cnt), 64'd255);
      check("sat_y", 64'(out_y), 64'h0104_0104);
    end
    @(posedge clk);
    #1;

`ifdef SUM_DIFF_FLAGS_EN
    send(255, 0, MODE_ACC, 1'b0);
    send(255, 0, MODE_ACC, 1'b1);
    in_valid = 1'b0;
    wait_out("flag_nowrap", got);
    if (got) begin
      check("flag_nowrap_sum", 64'(out_y[15:0]), 64'd510);
      check("flag_nowrap_c", 64'(out_flags[0]), 64'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 129; i++) send(255, 255, MODE_ACC, (i == 128));
    in_valid = 1'b0;
    wait_out("flag_wrap", got);
    if (got) check("flag_wrap_c", 64'(out_flags[0]), 64'd1);
    @(posedge clk);
    #1;
`endif

    // Randomized traffic with random backpressure.
    rnd_on = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           logic'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    send(0, 0, MODE_ACC, 1'b1);
    in_valid = 1'b0;
    rnd_on   = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("rnd_drained", 64'(exp_q.size()), 64'd0);
    check("rnd_idle", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
